// File: rtl/core_pkg.sv
// Shared encodings for the multicycle RV32I-subset core: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package core_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_JAL,
    S_BEQ
  } statetype;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALUOp: what the state asks of the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE: imm_src_of = IMM_S;
      OP_BEQ:   imm_src_of = IMM_B;
      OP_JAL:   imm_src_of = IMM_J;
      default:  imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp/funct3/op[5]/funct7b5 to ALUControl and
// flags whether funct3 names an operation this ALU implements.
module alu_decoder
  import core_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control,
  output logic       o_funct3_legal
);

  assign o_funct3_legal = !(i_funct3 inside {3'b001, 3'b011, 3'b101});

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // Only R-type may subtract; addi reuses instr[30] as immediate bit.
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b100:  o_alu_control = ALU_XOR;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Instruction FSM for the multicycle RV32I-subset core: one Moore state per
// clock driving datapath enables, mux selects and ALUControl.
module multicycle_controller
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_instr
);

  statetype   r_state;
  statetype   w_next;
  logic       w_pc_update;
  logic       w_branch;
  logic [1:0] w_alu_op;
  logic       w_funct3_legal;

  // NOTE: state register uses non-blocking assignment so every flop samples
  // pre-edge values; blocking here would race with anything reading r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next        = S_FETCH;
    w_pc_update   = 1'b0;
    w_branch      = 1'b0;
    w_alu_op      = ALUOP_ADD;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    illegal_instr = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRWrite     = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        w_pc_update = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        // Branch target lands in ALUOut while the opcode is inspected.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R: begin
            w_next        = w_funct3_legal ? S_EXECUTER : S_FETCH;
            illegal_instr = !w_funct3_legal;
          end
          OP_I: begin
            w_next        = w_funct3_legal ? S_EXECUTEI : S_FETCH;
            illegal_instr = !w_funct3_legal;
          end
          OP_JAL: w_next = S_JAL;
          OP_BEQ: w_next = S_BEQ;
          default: begin
            w_next        = S_FETCH;
            illegal_instr = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        w_next  = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA  = SRCA_RS1;
        ALUSrcB  = SRCB_RS2;
        w_alu_op = ALUOP_FUNCT;
        w_next   = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA  = SRCA_RS1;
        ALUSrcB  = SRCB_IMM;
        w_alu_op = ALUOP_FUNCT;
        w_next   = S_ALUWB;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_JAL: begin
        // PC takes the jump target from ALUOut while PC+4 is formed for rd.
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA  = SRCA_RS1;
        ALUSrcB  = SRCB_RS2;
        w_alu_op = ALUOP_SUB;
        w_branch = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign PCWrite = w_pc_update | (w_branch & Zero);
  assign ImmSrc  = imm_src_of(op);

  alu_decoder u_alu_decoder (
    .i_alu_op       (w_alu_op),
    .i_funct3       (funct3),
    .i_op5          (op[5]),
    .i_funct7b5     (funct7b5),
    .o_alu_control  (ALUControl),
    .o_funct3_legal (w_funct3_legal)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through the FSM and checks per-cycle outputs against hand-derived values.
module tb_multicycle_controller;
  import core_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic [2:0] aluc;
    logic       ill;
  } snap_t;

  snap_t snap [10];
  int    n_cyc, regw_cnt, memw_cnt, ill_cnt;
  int    total = 0;
  int    bad   = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered just after a negedge with the FSM in FETCH; returns at the
  // negedge where FETCH is seen again, with one snapshot per cycle.
  task automatic run_instr(input string tag, input logic [6:0] i_op,
                           input logic [2:0] i_f3, input logic i_f7, input logic i_zero);
    logic done;
    op = i_op; funct3 = i_f3; funct7b5 = i_f7; Zero = i_zero;
    n_cyc = 0; regw_cnt = 0; memw_cnt = 0; ill_cnt = 0; done = 1'b0;
    while (!done && n_cyc < 10) begin
      #1;
      snap[n_cyc] = '{PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                      ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr};
      regw_cnt += int'(RegWrite);
      memw_cnt += int'(MemWrite);
      ill_cnt  += int'(illegal_instr);
      n_cyc++;
      @(posedge clk);
      @(negedge clk);
      if (IRWrite) done = 1'b1;
    end
    check({tag, "_completes"}, 8'(done), 8'd1);
  endtask

  initial begin
    reset = 1'b1; op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;

    // Reset holds the FSM in FETCH, whose values are visible on the outputs.
    #1;
    check("rst_irwrite", 8'(IRWrite), 8'd1);
    check("rst_pcwrite", 8'(PCWrite), 8'd1);
    check("rst_srcb", 8'(ALUSrcB), 8'(SRCB_FOUR));
    check("rst_result", 8'(ResultSrc), 8'(RES_ALURESULT));
    check("rst_regwrite", 8'(RegWrite), 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // add interrupted by reset while in EXECUTER.
    op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1;
    check("abort_in_exec_srca", 8'(ALUSrcA), 8'(SRCA_RS1));
    check("abort_in_exec_aluc", 8'(ALUControl), 8'(ALU_ADD));
    #1 reset = 1'b1;
    #1;
    check("abort_async_irwrite", 8'(IRWrite), 8'd1);
    check("abort_async_regwrite", 8'(RegWrite), 8'd0);
    @(posedge clk); #1;
    check("abort_hold_regwrite", 8'(RegWrite), 8'd0);
    check("abort_hold_irwrite", 8'(IRWrite), 8'd1);
    @(negedge clk);
    reset = 1'b0;

    // add after reset.
    run_instr("add", OP_R, 3'b000, 1'b0, 1'b0);
    check("add_cycles", 8'(n_cyc), 8'd4);
    check("add_exec_aluc", 8'(snap[2].aluc), 8'(ALU_ADD));
    check("add_exec_srcb", 8'(snap[2].sb), 8'(SRCB_RS2));
    check("add_decode_srca", 8'(snap[1].sa), 8'(SRCA_OLDPC));
    check("add_wb_regwrite", 8'(snap[3].regw), 8'd1);
    check("add_regwrite_count", 8'(regw_cnt), 8'd1);

    run_instr("sub", OP_R, 3'b000, 1'b1, 1'b0);
    check("sub_exec_aluc", 8'(snap[2].aluc), 8'(ALU_SUB));

    run_instr("addi", OP_I, 3'b000, 1'b1, 1'b0);
    check("addi_cycles", 8'(n_cyc), 8'd4);
    check("addi_exec_aluc", 8'(snap[2].aluc), 8'(ALU_ADD));
    check("addi_exec_srcb", 8'(snap[2].sb), 8'(SRCB_IMM));

    run_instr("xori", OP_I, 3'b100, 1'b0, 1'b0);
    check("xori_exec_aluc", 8'(snap[2].aluc), 8'(ALU_XOR));

    run_instr("slt", OP_R, 3'b010, 1'b0, 1'b0);
    check("slt_exec_aluc", 8'(snap[2].aluc), 8'(ALU_SLT));

    run_instr("or", OP_R, 3'b110, 1'b0, 1'b0);
    check("or_exec_aluc", 8'(snap[2].aluc), 8'(ALU_OR));

    run_instr("andi", OP_I, 3'b111, 1'b0, 1'b0);
    check("andi_exec_aluc", 8'(snap[2].aluc), 8'(ALU_AND));

    run_instr("lw", OP_LOAD, 3'b010, 1'b0, 1'b0);
    check("lw_cycles", 8'(n_cyc), 8'd5);
    check("lw_memadr_srca", 8'(snap[2].sa), 8'(SRCA_RS1));
    check("lw_memread_adr", 8'(snap[3].adr), 8'd1);
    check("lw_memwb_result", 8'(snap[4].res), 8'(RES_DATA));
    check("lw_memwb_regwrite", 8'(snap[4].regw), 8'd1);
    check("lw_immsrc", 8'(snap[2].imm), 8'(IMM_I));
    check("lw_memwrite_count", 8'(memw_cnt), 8'd0);

    run_instr("sw", OP_STORE, 3'b010, 1'b0, 1'b0);
    check("sw_cycles", 8'(n_cyc), 8'd4);
    check("sw_memwrite_count", 8'(memw_cnt), 8'd1);
    check("sw_memwrite_cycle", 8'(snap[3].memw), 8'd1);
    check("sw_memwrite_adr", 8'(snap[3].adr), 8'd1);
    check("sw_immsrc", 8'(snap[1].imm), 8'(IMM_S));
    check("sw_regwrite_count", 8'(regw_cnt), 8'd0);

    run_instr("jal", OP_JAL, 3'b000, 1'b0, 1'b0);
    check("jal_cycles", 8'(n_cyc), 8'd4);
    check("jal_pcwrite", 8'(snap[2].pcw), 8'd1);
    check("jal_srcb", 8'(snap[2].sb), 8'(SRCB_FOUR));
    check("jal_wb_regwrite", 8'(snap[3].regw), 8'd1);
    check("jal_immsrc", 8'(snap[1].imm), 8'(IMM_J));

    run_instr("beq_taken", OP_BEQ, 3'b000, 1'b0, 1'b1);
    check("beq_taken_cycles", 8'(n_cyc), 8'd3);
    check("beq_taken_decode_pcwrite", 8'(snap[1].pcw), 8'd0);
    check("beq_taken_pcwrite", 8'(snap[2].pcw), 8'd1);
    check("beq_taken_aluc", 8'(snap[2].aluc), 8'(ALU_SUB));
    check("beq_taken_immsrc", 8'(snap[2].imm), 8'(IMM_B));

    run_instr("beq_not_taken", OP_BEQ, 3'b000, 1'b0, 1'b0);
    check("beq_nt_cycles", 8'(n_cyc), 8'd3);
    check("beq_nt_pcwrite", 8'(snap[2].pcw), 8'd0);
    check("beq_nt_regwrite_count", 8'(regw_cnt), 8'd0);

    run_instr("ecall", 7'b1110011, 3'b000, 1'b0, 1'b0);
    check("ecall_cycles", 8'(n_cyc), 8'd2);
    check("ecall_illegal_decode", 8'(snap[1].ill), 8'd1);
    check("ecall_illegal_count", 8'(ill_cnt), 8'd1);
    check("ecall_regwrite_count", 8'(regw_cnt), 8'd0);
    check("ecall_memwrite_count", 8'(memw_cnt), 8'd0);

    run_instr("sll", OP_R, 3'b001, 1'b0, 1'b0);
    check("sll_cycles", 8'(n_cyc), 8'd2);
    check("sll_illegal_count", 8'(ill_cnt), 8'd1);
    check("sll_regwrite_count", 8'(regw_cnt), 8'd0);

    run_instr("sltiu", OP_I, 3'b011, 1'b0, 1'b0);
    check("sltiu_illegal_count", 8'(ill_cnt), 8'd1);

    run_instr("add_after_illegal", OP_R, 3'b000, 1'b0, 1'b0);
    check("add2_cycles", 8'(n_cyc), 8'd4);
    check("add2_illegal_count", 8'(ill_cnt), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
